nt35510_bus_responder: RTL and testbench

- Responder end of the NT35510 8080-style parallel LCD bus; emulates the panel side for FPGA bring-up and loopback tests.
- Synchronises the strobes driven by the APB-to-LCD adapter and captures every write into a FIFO tagged command (rs=0) or data (rs=1).
- Answers read strobes by driving the data bus.
- Sits between the LCD pins (or a loopback of the adapter outputs) and a consumer stream interface.

---
 rtl/nt35510_bus_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_nt35510_bus_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nt35510_bus_responder.sv
// NT35510 8080-style bus responder: panel-side emulation for bring-up/loopback.
// Writes are captured into a show-ahead FIFO tagged command/data; reads are
// answered with rsp_data (data phase) or the last command word (command phase).
// Optional macro NT35510_PROTO_ERR_CHECK_EN adds a sticky proto_err output.
//
// state  | meaning
// IDLE   | waiting for a write (csel low) or read strobe falling edge
// WR_ACT | write strobe low; capture on its rising edge
// RD_ACT | read in progress; bus driven until the read strobe rises
module nt35510_bus_responder #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        LCD_csel,
    input  logic        LCD_rs,
    input  logic        LCD_wr,
    input  logic        LCD_rd,
    input  logic [23:0] LCD_data_in,
    output logic [23:0] LCD_data_out,
    output logic        LCD_data_oe,
    output logic        cap_valid,
    input  logic        cap_ready,
    output logic        cap_is_cmd,
    output logic [23:0] cap_data,
    input  logic [23:0] rsp_data,
    output logic        rd_strobe,
    output logic [23:0] last_cmd,
    output logic        ovf,
    input  logic        flag_clr
`ifdef NT35510_PROTO_ERR_CHECK_EN
    ,
    output logic        proto_err
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT} state_t;

    logic [SYNC_STAGES-1:0]       csel_sync_q, csel_sync_d;
    logic [SYNC_STAGES-1:0]       rs_sync_q, rs_sync_d;
    logic [SYNC_STAGES-1:0]       wr_sync_q, wr_sync_d;
    logic [SYNC_STAGES-1:0]       rd_sync_q, rd_sync_d;
    logic [SYNC_STAGES-1:0][23:0] data_sync_q, data_sync_d;
    logic                         wr_dly_q, wr_dly_d, rd_dly_q, rd_dly_d;

    state_t      state_q, state_d;
    logic        rd_first_q, rd_first_d;
    logic [23:0] data_out_q, data_out_d;
    logic        oe_q, oe_d;
    logic        rd_strobe_q, rd_strobe_d;
    logic [23:0] last_cmd_q, last_cmd_d;
    logic        ovf_q, ovf_d;
    logic        proto_hit;

    logic [24:0]   mem_q [FIFO_DEPTH];
    logic [24:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic        csel_s, rs_s, wr_s, rd_s;
    logic [23:0] data_s;
    logic        wr_fall, wr_rise, rd_fall;
    logic        push, pop, full, push_ok;
    logic [24:0] head;

    // Shift the raw pins through the synchroniser chains and track last synced strobes
    always_comb begin
        csel_sync_d = {csel_sync_q[SYNC_STAGES-2:0], LCD_csel};
        rs_sync_d   = {rs_sync_q[SYNC_STAGES-2:0], LCD_rs};
        wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], LCD_wr};
        rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], LCD_rd};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], LCD_data_in};
        csel_s      = csel_sync_q[SYNC_STAGES-1];
        rs_s        = rs_sync_q[SYNC_STAGES-1];
        wr_s        = wr_sync_q[SYNC_STAGES-1];
        rd_s        = rd_sync_q[SYNC_STAGES-1];
        data_s      = data_sync_q[SYNC_STAGES-1];
        wr_dly_d    = wr_s;
        rd_dly_d    = rd_s;
        wr_fall     = wr_dly_q & ~wr_s;
        wr_rise     = ~wr_dly_q & wr_s;
        rd_fall     = rd_dly_q & ~rd_s;
    end

    // Synchroniser and edge-detect registers, reset to the idle bus level
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            csel_sync_q <= '1;
            rs_sync_q   <= '0;
            wr_sync_q   <= '1;
            rd_sync_q   <= '1;
            data_sync_q <= '0;
            wr_dly_q    <= 1'b1;
            rd_dly_q    <= 1'b1;
        end else begin
            csel_sync_q <= csel_sync_d;
            rs_sync_q   <= rs_sync_d;
            wr_sync_q   <= wr_sync_d;
            rd_sync_q   <= rd_sync_d;
            data_sync_q <= data_sync_d;
            wr_dly_q    <= wr_dly_d;
            rd_dly_q    <= rd_dly_d;
        end
    end

    // Bus FSM next state, capture request and read response
    always_comb begin
        state_d     = state_q;
        rd_first_d  = 1'b0;
        data_out_d  = data_out_q;
        oe_d        = oe_q;
        rd_strobe_d = 1'b0;
        last_cmd_d  = last_cmd_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_fall && !csel_s) begin
                    state_d = WR_ACT;
                end else if (rd_fall) begin
                    state_d    = RD_ACT;
                    rd_first_d = 1'b1;
                end
            end
            WR_ACT: begin
                if (wr_rise) begin
                    push = 1'b1;
                    if (!rs_s) last_cmd_d = data_s;
                    state_d = IDLE;
                end
            end
            RD_ACT: begin
                // Exit on strobe level so a read shorter than the entry cycle cannot hang
                if (rd_first_q) begin
                    data_out_d  = rs_s ? rsp_data : last_cmd_q;
                    oe_d        = 1'b1;
                    rd_strobe_d = 1'b1;
                end else if (rd_s) begin
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef NT35510_PROTO_ERR_CHECK_EN
        proto_hit = (!wr_s && !rd_s) || (wr_fall && csel_s) ||
                    ((wr_fall || rd_fall) && (state_q != IDLE));
`else
        proto_hit = 1'b0;
`endif
    end

    // FIFO pointer, storage and sticky flag update
    always_comb begin
        full    = (count_q == CW'(FIFO_DEPTH));
        pop     = (count_q != '0) && cap_ready;
        push_ok = push && (!full || pop);
        mem_d   = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = {~rs_s, data_s};
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = ovf_q;
        if (flag_clr) ovf_d = 1'b0;
        if (push && full && !pop) ovf_d = 1'b1;
        head = mem_q[rd_ptr_q];
    end

    // FIFO storage carries no reset; pointers alone define its contents
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            rd_first_q  <= 1'b0;
            data_out_q  <= '0;
            oe_q        <= 1'b0;
            rd_strobe_q <= 1'b0;
            last_cmd_q  <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_first_q  <= rd_first_d;
            data_out_q  <= data_out_d;
            oe_q        <= oe_d;
            rd_strobe_q <= rd_strobe_d;
            last_cmd_q  <= last_cmd_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

`ifdef NT35510_PROTO_ERR_CHECK_EN
    logic proto_err_q, proto_err_d;

    // Sticky protocol error; a same-cycle violation beats the clear
    always_comb begin
        proto_err_d = proto_err_q;
        if (flag_clr) proto_err_d = 1'b0;
        if (proto_hit) proto_err_d = 1'b1;
    end

    // Protocol error register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) proto_err_q <= 1'b0;
        else       proto_err_q <= proto_err_d;
    end

    assign proto_err = proto_err_q;
`else
    logic unused_proto;
    assign unused_proto = proto_hit;
`endif

    assign LCD_data_out = data_out_q;
    assign LCD_data_oe  = oe_q;
    assign rd_strobe    = rd_strobe_q;
    assign last_cmd     = last_cmd_q;
    assign ovf          = ovf_q;
    assign cap_valid    = (count_q != '0);
    assign cap_is_cmd   = cap_valid & head[24];
    assign cap_data     = cap_valid ? head[23:0] : 24'd0;

endmodule

// File: tb/tb_nt35510_bus_responder.sv
// Self-checking bench for nt35510_bus_responder: table-driven directed tests,
// timed corner sequences and a randomized run against a queue-based model.
module tb_nt35510_bus_responder;

    localparam int DEPTH = 16;
    localparam int SYNC  = 2;

    logic        clk, nrst;
    logic        LCD_csel, LCD_rs, LCD_wr, LCD_rd;
    logic [23:0] LCD_data_in, LCD_data_out;
    logic        LCD_data_oe;
    logic        cap_valid, cap_ready, cap_is_cmd;
    logic [23:0] cap_data, rsp_data, last_cmd;
    logic        rd_strobe, ovf, flag_clr;
`ifdef NT35510_PROTO_ERR_CHECK_EN
    logic        proto_err;
`endif

    nt35510_bus_responder #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .nrst(nrst),
        .LCD_csel(LCD_csel), .LCD_rs(LCD_rs), .LCD_wr(LCD_wr), .LCD_rd(LCD_rd),
        .LCD_data_in(LCD_data_in), .LCD_data_out(LCD_data_out), .LCD_data_oe(LCD_data_oe),
        .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_is_cmd(cap_is_cmd),
        .cap_data(cap_data), .rsp_data(rsp_data), .rd_strobe(rd_strobe),
        .last_cmd(last_cmd), .ovf(ovf), .flag_clr(flag_clr)
`ifdef NT35510_PROTO_ERR_CHECK_EN
        , .proto_err(proto_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_cmd;
        logic [23:0] data;
    } ent_t;

    typedef struct {
        logic        rs;
        logic [23:0] data;
        logic        exp_is_cmd;
        logic [23:0] exp_data;
    } vec_t;

    vec_t        tbl [DEPTH+2];
    ent_t        mq [$];
    logic [23:0] m_last_cmd;
    logic        m_ovf;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        LCD_csel = 1'b1; LCD_rs = 1'b0; LCD_wr = 1'b1; LCD_rd = 1'b1;
        LCD_data_in = '0; cap_ready = 1'b0; flag_clr = 1'b0; rsp_data = '0;
        ticks(2);
        nrst = 1'b1;
        ticks(2);
        mq.delete();
        m_last_cmd = '0;
        m_ovf = 1'b0;
    endtask

    // mode 0: plain write; 1: pop the head on the capture cycle; 2: flag_clr on the capture cycle
    task automatic bus_write(input logic rs, input logic [23:0] d, input int len, input int mode);
        LCD_rs = rs; LCD_data_in = d; LCD_csel = 1'b0;
        tick();
        LCD_wr = 1'b0;
        ticks(len);
        LCD_wr = 1'b1;
        if (mode == 1) begin
            ticks(SYNC);
            if (mq.size() > 0) check("cap_pop_head", {8'd0, cap_data}, {8'd0, mq[0].data});
            cap_ready = 1'b1; tick(); cap_ready = 1'b0;
            if (mq.size() > 0) void'(mq.pop_front());
        end else if (mode == 2) begin
            ticks(SYNC);
            flag_clr = 1'b1; tick(); flag_clr = 1'b0;
            m_ovf = 1'b0;
        end
        ticks(3);
        LCD_csel = 1'b1;
        ticks(3);
        if (mq.size() < DEPTH) mq.push_back({~rs, d});
        else m_ovf = 1'b1;
        if (!rs) m_last_cmd = d;
    endtask

    task automatic pop_check(input string tag, input logic exp_valid,
                             input logic exp_is_cmd, input logic [23:0] exp_data);
        check({tag, "_valid"}, cap_valid, exp_valid);
        if (exp_valid) begin
            check({tag, "_is_cmd"}, cap_is_cmd, exp_is_cmd);
            check({tag, "_data"}, {8'd0, cap_data}, {8'd0, exp_data});
            cap_ready = 1'b1; tick(); cap_ready = 1'b0;
            if (mq.size() > 0) void'(mq.pop_front());
        end
    endtask

    task automatic model_pop(input string tag);
        if (mq.size() > 0) pop_check(tag, 1'b1, mq[0].is_cmd, mq[0].data);
        else pop_check(tag, 1'b0, 1'b0, 24'd0);
    endtask

    task automatic bus_read(input logic rs, output int lat_on, output int strobes,
                            output int lat_off, output logic [23:0] dout_on, output logic [23:0] dout_off);
        LCD_rs = rs; LCD_rd = 1'b0;
        lat_on = 0; strobes = 0; lat_off = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rd_strobe) strobes++;
            if (LCD_data_oe && lat_on == 0) lat_on = i + 1;
        end
        dout_on = LCD_data_out;
        LCD_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_strobe) strobes++;
            if (!LCD_data_oe && lat_off == 0) lat_off = i + 1;
        end
        dout_off = LCD_data_out;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lon, nstr, loff, r;
        logic [23:0] d_on, d_off, exp_rd;
        logic        rsb;

        tbl[0] = '{1'b0, 24'h00002C, 1'b1, 24'h00002C};
        tbl[1] = '{1'b1, 24'h00F800, 1'b0, 24'h00F800};
        for (int i = 2; i < DEPTH + 2; i++) begin
            logic [23:0] v;
            v = 24'h100000 + 24'(i * 257);
            tbl[i] = '{i[0], v, ~i[0], v};
        end

        do_reset();
        check("rst_oe", LCD_data_oe, 0);
        check("rst_data_out", {8'd0, LCD_data_out}, 0);
        check("rst_cap_valid", cap_valid, 0);
        check("rst_cap_is_cmd", cap_is_cmd, 0);
        check("rst_cap_data", {8'd0, cap_data}, 0);
        check("rst_rd_strobe", rd_strobe, 0);
        check("rst_last_cmd", {8'd0, last_cmd}, 0);
        check("rst_ovf", ovf, 0);
`ifdef NT35510_PROTO_ERR_CHECK_EN
        check("rst_proto_err", proto_err, 0);
`endif

        // command then data write
        bus_write(tbl[0].rs, tbl[0].data, 5, 0);
        bus_write(tbl[1].rs, tbl[1].data, 5, 0);
        check("cmdwr_last_cmd", {8'd0, last_cmd}, 32'h00002C);
        for (int i = 0; i < 2; i++) pop_check("cmdwr_pop", 1'b1, tbl[i].exp_is_cmd, tbl[i].exp_data);
        check("cmdwr_empty", cap_valid, 0);

        // data read
        rsp_data = 24'h123456;
        bus_read(1'b1, lon, nstr, loff, d_on, d_off);
        check("rd_oe_within_4", (lon >= 1 && lon <= 4), 1);
        check("rd_data", {8'd0, d_on}, 32'h123456);
        check("rd_strobe_count", nstr, 1);
        check("rd_oe_off_within_4", (loff >= 1 && loff <= 4), 1);
        check("rd_data_hold", {8'd0, d_off}, 32'h123456);

        // command read
        bus_write(1'b0, 24'h0000DA, 3, 0);
        model_pop("cmdrd_pop");
        bus_read(1'b0, lon, nstr, loff, d_on, d_off);
        check("cmdrd_data", {8'd0, d_on}, 32'h0000DA);
        check("cmdrd_strobe_count", nstr, 1);

        // write with csel high is ignored
        LCD_rs = 1'b1; LCD_data_in = 24'h777777; LCD_wr = 1'b0; ticks(4); LCD_wr = 1'b1; ticks(6);
        check("cselhi_no_capture", cap_valid, 0);

        // overflow, flag_clr, and overflow beating a same-cycle clear
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) bus_write(tbl[i].rs, tbl[i].data, 2, 0);
        check("ovf_set", ovf, 1);
        flag_clr = 1'b1; tick(); flag_clr = 1'b0;
        check("ovf_cleared", ovf, 0);
        bus_write(1'b1, 24'hBADBAD, 2, 2);
        check("ovf_wins_over_clr", ovf, 1);
        for (int i = 0; i < DEPTH; i++) pop_check("ovf_drain", 1'b1, tbl[i].exp_is_cmd, tbl[i].exp_data);
        check("ovf_drained_empty", cap_valid, 0);

        // full FIFO with pop on the capture cycle
        do_reset();
        for (int i = 0; i < DEPTH; i++) bus_write(tbl[i].rs, tbl[i].data, 1, 0);
        bus_write(1'b1, 24'hABCDEF, 2, 1);
        check("fullpop_no_ovf", ovf, 0);
        for (int i = 1; i < DEPTH; i++) pop_check("fullpop_drain", 1'b1, tbl[i].exp_is_cmd, tbl[i].exp_data);
        pop_check("fullpop_tail", 1'b1, 1'b0, 24'hABCDEF);
        check("fullpop_empty", cap_valid, 0);

        // reset in the middle of a read
        do_reset();
        bus_write(1'b1, 24'h0F0F0F, 2, 0);
        rsp_data = 24'h5A5A5A; LCD_rs = 1'b1; LCD_rd = 1'b0;
        lon = 0;
        for (int i = 0; i < 10 && lon == 0; i++) begin
            tick();
            if (LCD_data_oe) lon = i + 1;
        end
        check("midrd_oe_before_reset", LCD_data_oe, 1);
        nrst = 1'b0;
        #1;
        check("midrd_oe_async_drop", LCD_data_oe, 0);
        check("midrd_fifo_empty", cap_valid, 0);
        LCD_rd = 1'b1;
        ticks(2);
        nrst = 1'b1;
        mq.delete(); m_last_cmd = '0; m_ovf = 1'b0;
        ticks(4);
        check("midrd_after_release_oe", LCD_data_oe, 0);

`ifdef NT35510_PROTO_ERR_CHECK_EN
        do_reset();
        LCD_csel = 1'b0; LCD_wr = 1'b0; LCD_rd = 1'b0;
        ticks(4);
        LCD_wr = 1'b1; LCD_rd = 1'b1; LCD_csel = 1'b1;
        ticks(6);
        check("proto_both_low", proto_err, 1);
        flag_clr = 1'b1; tick(); flag_clr = 1'b0;
        check("proto_cleared", proto_err, 0);
        do_reset();
`endif

        // randomized traffic against the queue model
        do_reset();
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                rsb = 1'($urandom_range(0, 1));
                bus_write(rsb, 24'($urandom), $urandom_range(1, 6), 0);
                check("rnd_last_cmd", {8'd0, last_cmd}, {8'd0, m_last_cmd});
                check("rnd_ovf", ovf, m_ovf);
            end else if (r < 8) begin
                model_pop("rnd_pop");
            end else if (r == 8) begin
                flag_clr = 1'b1; tick(); flag_clr = 1'b0;
                m_ovf = 1'b0;
                check("rnd_flag_clr", ovf, 0);
            end else begin
                rsb = 1'($urandom_range(0, 1));
                rsp_data = 24'($urandom);
                exp_rd = rsb ? rsp_data : m_last_cmd;
                bus_read(rsb, lon, nstr, loff, d_on, d_off);
                check("rnd_rd_data", {8'd0, d_on}, {8'd0, exp_rd});
                check("rnd_rd_strobe", nstr, 1);
            end
        end
        while (mq.size() > 0) model_pop("rnd_drain");
        check("rnd_final_empty", cap_valid, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
